// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and width helper for the CNN back-end stages.
package cnn_pkg;

  localparam int PIX    = 16;
  localparam int OFM_DW = 16;
  localparam int OFM_AW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } cls_state_e;

  // Elaboration-time ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ofm_rd_addr_gen.sv
// Walks the OFM filter-major, one read per cycle, and tags each read with
// (valid, pixel, filter) delayed one cycle to line up with the returning data.
module ofm_rd_addr_gen
  import cnn_pkg::*;
#(
  parameter int  N   = 4,
  parameter int  AW  = OFM_AW,
  parameter int  PIX = cnn_pkg::PIX,
  localparam int FW  = clog2(N),
  localparam int PW  = clog2(PIX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] base_adr,
  output logic          rd_en,
  output logic [AW-1:0] rd_adr,
  output logic          last_rd,
  output logic          d_valid,
  output logic [PW-1:0] d_p,
  output logic [FW-1:0] d_f
);

  localparam logic [PW-1:0] P_LAST = PW'(PIX - 1);
  localparam logic [FW-1:0] F_LAST = FW'(N - 1);

  logic          reading;
  logic [AW-1:0] base_q;
  logic [PW-1:0] p;
  logic [FW-1:0] f;

  assign rd_en   = reading;
  // Modulo-2^AW add: a base near the top of the address space wraps to 0.
  assign rd_adr  = base_q + AW'(f) * AW'(PIX) + AW'(p);
  assign last_rd = reading && (p == P_LAST) && (f == F_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reading <= 1'b0;
      base_q  <= '0;
      p       <= '0;
      f       <= '0;
      d_valid <= 1'b0;
      d_p     <= '0;
      d_f     <= '0;
    end else begin
      d_valid <= reading;
      d_p     <= p;
      d_f     <= f;
      if (load) begin
        reading <= 1'b1;
        base_q  <= base_adr;
        p       <= '0;
        f       <= '0;
      end else if (reading) begin
        if (p == P_LAST) begin
          p <= '0;
          if (f == F_LAST) begin
            f       <= '0;
            reading <= 1'b0;
          end else begin
            f <= f + 1'b1;
          end
        end else begin
          p <= p + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ofm_classifier.sv
// Sums each filter's pooled OFM words and reports the filter with the largest
// signed sum (lowest index on ties) as the class result.
module ofm_classifier
  import cnn_pkg::*;
#(
  parameter int  N   = 4,
  parameter int  DW  = OFM_DW,
  parameter int  AW  = OFM_AW,
  parameter int  PIX = cnn_pkg::PIX,
  localparam int IW  = clog2(N),
  localparam int SW  = DW + 4,
  localparam int PW  = clog2(PIX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_adr,
  output logic          ofm_rd_en,
  output logic [AW-1:0] ofm_rd_adr,
  input  logic [DW-1:0] ofm_rd_data,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] class_idx,
  output logic [SW-1:0] class_score,
  output cls_state_e    dbg_state
);

  // Protocol: start is a level sampled only in IDLE (ignored while busy or
  // in FIN, never queued); done is a one-cycle pulse in FIN, and class_idx /
  // class_score stay valid from then until the next result or reset.

  localparam logic [PW-1:0] P_LAST = PW'(PIX - 1);

  cls_state_e state;

  logic                 load;
  logic                 last_rd;
  logic                 d_valid;
  logic [PW-1:0]        d_p;
  logic [IW-1:0]        d_f;

  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] best;
  logic [IW-1:0]        idx;
  logic signed [SW-1:0] word_ext;
  logic signed [SW-1:0] total;
  logic signed [SW-1:0] best_nxt;
  logic [IW-1:0]        idx_nxt;

  assign load      = (state == ST_IDLE) && start;
  assign dbg_state = state;

  ofm_rd_addr_gen #(
    .N   (N),
    .AW  (AW),
    .PIX (PIX)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .base_adr (base_adr),
    .rd_en    (ofm_rd_en),
    .rd_adr   (ofm_rd_adr),
    .last_rd  (last_rd),
    .d_valid  (d_valid),
    .d_p      (d_p),
    .d_f      (d_f)
  );

  assign word_ext = {{(SW - DW){ofm_rd_data[DW-1]}}, ofm_rd_data};
  assign total    = acc + word_ext;

  // Filter 0 always seeds best so an all-negative map still yields a winner.
  always_comb begin
    best_nxt = best;
    idx_nxt  = idx;
    if (d_valid && (d_p == P_LAST) && ((d_f == '0) || (total > best))) begin
      best_nxt = total;
      idx_nxt  = d_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      acc         <= '0;
      best        <= '0;
      idx         <= '0;
    end else begin
      if (d_valid) begin
        acc  <= (d_p == P_LAST) ? '0 : total;
        best <= best_nxt;
        idx  <= idx_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_READ;
            busy  <= 1'b1;
            acc   <= '0;
            best  <= '0;
            idx   <= '0;
          end
        end
        ST_READ: begin
          if (last_rd) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Last word lands now; register the result so done rises with FIN.
          class_idx   <= idx_nxt;
          class_score <= best_nxt;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_FIN;
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_classifier.sv
// Directed bench for ofm_classifier: OFM memory model, address scoreboard,
// per-cycle handshake checks and hand-computed class results.
module tb_ofm_classifier;
  import cnn_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic        ofm_rd_en;
  logic [31:0] ofm_rd_adr;
  logic [15:0] ofm_rd_data = '0;
  logic        busy;
  logic        done;
  logic [1:0]  class_idx;
  logic [19:0] class_score;
  cls_state_e  dbg_state;

  ofm_classifier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_adr    (base_adr),
    .ofm_rd_en   (ofm_rd_en),
    .ofm_rd_adr  (ofm_rd_adr),
    .ofm_rd_data (ofm_rd_data),
    .busy        (busy),
    .done        (done),
    .class_idx   (class_idx),
    .class_score (class_score),
    .dbg_state   (dbg_state)
  );

  // OFM memory model: data one cycle after the read strobe
  logic [15:0] mem [64];
  logic [31:0] cur_base = '0;
  logic [31:0] off;
  always @(posedge clk) begin
    if (ofm_rd_en) begin
      off = ofm_rd_adr - cur_base;
      ofm_rd_data <= mem[off[5:0]];
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] sc(input int v);
    logic [31:0] t;
    t = v;
    return {12'b0, t[19:0]};
  endfunction

  // driver tasks
  task automatic fill(input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] v3);
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: mem[i] = v0;
        1: mem[i] = v1;
        2: mem[i] = v2;
        default: mem[i] = v3;
      endcase
    end
  endtask

  task automatic push_adrs(input logic [31:0] base);
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic launch(input logic [31:0] base);
    cur_base = base;
    push_adrs(base);
    @(negedge clk);
    base_adr = base;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Entered at the negedge just before edge 1 of a run (edge 0 accepted start).
  task automatic run_body(input string name, input int exp_idx, input int exp_score,
                          input bit poke, input bit chain);
    logic [31:0] e;
    for (int k = 1; k <= 66; k++) begin
      if (poke) start = (k == 10);
      check({name, ".busy"}, 32'(busy), 32'(k <= 65));
      check({name, ".rd_en"}, 32'(ofm_rd_en), 32'(k <= 64));
      if (k <= 64) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({name, ".rd_adr"}, ofm_rd_adr, e);
        end else begin
          check({name, ".adr_q"}, 32'(exp_q.size()), 32'd1);
        end
      end
      check({name, ".done"}, 32'(done), 32'(k == 66));
      if (k == 66) begin
        check({name, ".idx"}, 32'(class_idx), 32'(exp_idx));
        check({name, ".score"}, {12'b0, class_score}, sc(exp_score));
        if (chain) start = 1'b1;
      end
      @(negedge clk);
    end
    check({name, ".done_clr"}, 32'(done), 32'd0);
    check({name, ".idx_hold"}, 32'(class_idx), 32'(exp_idx));
    check({name, ".score_hold"}, {12'b0, class_score}, sc(exp_score));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.rd_en", 32'(ofm_rd_en), 32'd0);
    check("rst.rd_adr", ofm_rd_adr, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.idx", 32'(class_idx), 32'd0);
    check("rst.score", {12'b0, class_score}, 32'd0);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // ascending filters
    fill(16'd1, 16'd2, 16'd3, 16'd4);
    launch(32'h0);
    run_body("t1", 3, 64, 1'b0, 1'b0);

    // all negative, filter 0 wins; start poked while busy
    fill(16'hFFFF, 16'hFFFB, 16'hFFFB, 16'hFFFB);
    launch(32'h0);
    run_body("t2", 0, -16, 1'b1, 1'b0);

    // tie between filters 1 and 2
    fill(16'd0, 16'd6, 16'd0, 16'd0);
    for (int i = 16; i < 20; i++) mem[i] = 16'd7;
    mem[32] = 16'd100;
    launch(32'h100);
    run_body("t3", 1, 100, 1'b0, 1'b0);

    // address wrap; start held through done restarts straight after FIN
    fill(16'd2, 16'hFFFD, 16'd5, 16'd4);
    launch(32'hFFFF_FFF8);
    run_body("t4", 2, 80, 1'b0, 1'b1);
    fill(16'h8000, 16'h8000, 16'h7FFF, 16'h8000);
    push_adrs(cur_base);
    @(negedge clk);
    start = 1'b0;
    run_body("t5", 2, 524272, 1'b0, 1'b0);

    // reset in the middle of READ
    fill(16'd1, 16'd1, 16'd1, 16'd1);
    launch(32'h0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst.rd_en", 32'(ofm_rd_en), 32'd0);
    check("mid_rst.rd_adr", ofm_rd_adr, 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.done", 32'(done), 32'd0);
    check("mid_rst.idx", 32'(class_idx), 32'd0);
    check("mid_rst.score", {12'b0, class_score}, 32'd0);
    check("mid_rst.state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_rst.rd_en", 32'(ofm_rd_en), 32'd0);

    // fresh run after reset, tie between 1 and 3
    fill(16'd3, 16'd9, 16'hFFFE, 16'd9);
    launch(32'h40);
    run_body("t7", 1, 144, 1'b0, 1'b0);

    check("final.exp_q", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ofm_classifier.md
Name: ofm_classifier

Overview:
- Downstream stage of the CNN top. Started by the CNN's final done pulse (done2).
- Reads the pooled output feature map (OFM) memory: N filters × 16 words (4x4 per filter), contiguous from a base address, filter-major.
- Sums each filter's 16 signed words and selects the filter with the largest sum.
- Reports the class index and score with a one-cycle done pulse.

Parameters:
- N, 4, number of filters / classes (≥2)
- DW, 16, OFM word width, signed two's complement
- AW, 32, OFM address width (matches OFM_adr_in)
- PIX, 16, words per filter (4x4 pooled map)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin classification; driven by CNN done2
- base_adr  in  AW  OFM address of filter 0, word 0; latched on accepted start
- ofm_rd_en  out  1  OFM read strobe
- ofm_rd_adr  out  AW  OFM read address
- ofm_rd_data  in  DW  OFM read data, valid exactly 1 cycle after ofm_rd_en
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, result valid
- class_idx  out  $clog2(N)  winning filter index
- class_score  out  DW+4  winning filter sum, signed

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. ofm_rd_en, ofm_rd_adr, busy, done, class_idx, class_score and all counters/accumulators = 0. Reset overrides everything, including mid-operation; no further reads issue after reset is sampled.
- States: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 latches base_adr, clears filter counter f, pixel counter p, acc and best. Next state READ.
  - start=0 stays IDLE.
- READ:
  - ofm_rd_en=1 every cycle; ofm_rd_adr = base + f*PIX + p, computed modulo 2^AW (wrap-around allowed).
  - p increments each cycle; at p=PIX-1, p returns to 0 and f increments.
  - After the read with f=N-1, p=PIX-1, next state DRAIN.
  - Reads issue on N*PIX consecutive cycles, with no gaps.
- Data path: a delayed read-valid flag (rd_en registered 1 cycle) qualifies ofm_rd_data.
  - Each valid word is sign-extended to DW+4 and added to acc.
  - On the valid word with delayed p=PIX-1, total = acc + word is formed combinationally:
    - if delayed f=0 or total > best (strict signed compare), best<=total and idx<=f;
    - acc<=0 the same edge.
  - Ties keep the lower index.
- DRAIN: ofm_rd_en=0. Accepts the final data word and performs the last compare. Next state FIN.
- FIN:
  - class_idx<=idx, class_score<=best, done<=1 for exactly one cycle, busy<=0. Next state IDLE.
- Timing: cycle 0 is the edge where start is sampled in IDLE. Reads occupy cycles 1..N*PIX. done is high in cycle N*PIX+2; with N=4, PIX=16, that is cycle 66.
- busy is high in cycles 1..N*PIX+1.
- start while busy or in FIN is ignored; no queuing.
- start in the same cycle done is high is accepted, because state is IDLE at the next edge.
- class_idx and class_score hold their values until the next FIN or reset.
- Width: DW+4 bits holds the sum of 16 DW-bit signed words without overflow. No saturation is needed.

Decomposition:
- Shared package cnn_pkg:
  - PIX=16 constant;
  - OFM DW/AW defaults;
  - state encoding for IDLE/READ/DRAIN/FIN;
  - clog2 function.
- One sub-module, ofm_rd_addr_gen, contains:
  - the p/f counters;
  - the base+offset adder;
  - the last-read flag;
  - the delayed (valid, p, f) tags.
- Accumulate/compare and the FSM stay in ofm_classifier.

Test Plan:
- N=4, base=0, filter k words all = k+1 → class_idx=3, class_score=64; done in cycle 66 exactly; 64 contiguous reads, addresses 0..63.
- Filter 0 words = -1, filters 1..3 words = -5 → class_idx=0, class_score=-16 (all sums negative, filter-0 init path).
- Filters 1 and 2 both sum to 100, others 0 → class_idx=1 (tie keeps lower index).
- base=32'hFFFF_FFF8 → addresses FFFF_FFF8..FFFF_FFFF, then 0..0x37 (wrap). Results match the unwrapped model.
- All words 16'h7FFF in filter 2, others 16'h8000 → class_idx=2, class_score=524272 (no overflow in DW+4).
- rst_n=0 at cycle 20 mid-READ → next cycle ofm_rd_en=0, busy=0, outputs 0. A start pulse during busy is ignored. A fresh start after reset completes correctly. start coincident with done restarts immediately.
